// File: rtl/multicycle_control_fsm.sv
// Multicycle Moore sequencer for the ARM-subset datapath: drives mux selects and
// write enables per phase, owns the NZCV flags and condition evaluation.
module multicycle_control_fsm #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [3:0]  State
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;

    logic [3:0] r_state;
    logic [3:0] r_flags;
    logic       r_condex;

    logic [3:0] w_next;
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic       w_i;
    logic [3:0] w_cmd;
    logic       w_s;
    logic       w_u;
    logic       w_l;
    logic       w_rd15;
    logic       w_ready;
    logic       w_condex;
    logic [1:0] w_dp_ctl;
    logic       w_nowrite;
    logic [1:0] w_flagw;
    logic       w_n, w_z, w_c, w_v;

    assign w_cond  = Instr[19:16];
    assign w_op    = Instr[15:14];
    assign w_i     = Instr[13];
    assign w_cmd   = Instr[12:9];
    assign w_s     = Instr[8];
    assign w_u     = Instr[11];
    assign w_l     = Instr[8];
    assign w_rd15  = (Instr[3:0] == 4'hF);
    assign w_ready = USE_MEM_READY ? MemReady : 1'b1;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_dp_ctl  = 2'b00;
        w_nowrite = 1'b0;
        w_flagw   = 2'b00;
        case (w_cmd)
            4'b0100: begin w_dp_ctl = 2'b00; w_flagw = w_s ? 2'b11 : 2'b00; end
            4'b0010: begin w_dp_ctl = 2'b01; w_flagw = w_s ? 2'b11 : 2'b00; end
            4'b0000: begin w_dp_ctl = 2'b10; w_flagw = w_s ? 2'b10 : 2'b00; end
            4'b1100: begin w_dp_ctl = 2'b11; w_flagw = w_s ? 2'b10 : 2'b00; end
            4'b1010: begin w_dp_ctl = 2'b01; w_nowrite = 1'b1; w_flagw = 2'b11; end
            default: begin w_dp_ctl = 2'b00; w_nowrite = 1'b1; w_flagw = 2'b00; end
        endcase
    end

    always_comb begin
        w_condex = 1'b0;
        case (w_cond)
            4'b0000: w_condex = w_z;
            4'b0001: w_condex = ~w_z;
            4'b0010: w_condex = w_c;
            4'b0011: w_condex = ~w_c;
            4'b0100: w_condex = w_n;
            4'b0101: w_condex = ~w_n;
            4'b0110: w_condex = w_v;
            4'b0111: w_condex = ~w_v;
            4'b1000: w_condex = w_c & ~w_z;
            4'b1001: w_condex = ~w_c | w_z;
            4'b1010: w_condex = (w_n == w_v);
            4'b1011: w_condex = (w_n != w_v);
            4'b1100: w_condex = ~w_z & (w_n == w_v);
            4'b1101: w_condex = w_z | (w_n != w_v);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = w_i ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = w_l ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            // A suppressed store has nothing to wait for.
            S_MEMWRITE: w_next = (!r_condex || w_ready) ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_flags  <= '0;
            r_condex <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_MEMADR) begin
                r_condex <= w_condex;
            end
            if (r_state == S_EXECUTER || r_state == S_EXECUTEI) begin
                r_condex <= w_condex;
                if (w_condex) begin
                    if (w_flagw[1]) r_flags[3:2] <= ALUFlags[3:2];
                    if (w_flagw[0]) r_flags[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        RegWrite   = 1'b0;
        State      = r_state;
        case (r_state)
            S_FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = w_ready;
                PCWrite   = w_ready;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (w_op)
                    2'b01:   begin ImmSrc = 2'b01; RegSrc = {~w_l, 1'b0}; end
                    2'b10:   begin ImmSrc = 2'b10; RegSrc = 2'b01; end
                    default: begin ImmSrc = 2'b00; RegSrc = 2'b00; end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_u ? 2'b00 : 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = r_condex;
                PCWrite   = r_condex & w_rd15;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = r_condex;
            end
            S_EXECUTER: ALUControl = w_dp_ctl;
            S_EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_dp_ctl;
            end
            S_ALUWB: begin
                RegWrite = r_condex & ~w_nowrite;
                PCWrite  = r_condex & ~w_nowrite & w_rd15;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                ImmSrc    = 2'b10;
                RegSrc    = 2'b01;
                PCWrite   = w_condex;
            end
            default: State = r_state;
        endcase
        // Reset gates every output combinationally so an in-flight enable drops at once.
        if (!reset) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            ResultSrc  = '0;
            ALUControl = '0;
            ALUSrcA    = '0;
            ALUSrcB    = '0;
            ImmSrc     = '0;
            RegSrc     = '0;
            RegWrite   = 1'b0;
            State      = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: linear instruction sequence with
// hand-computed per-cycle expectations.
module tb_multicycle_control_fsm;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUControl, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0]  State;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    multicycle_control_fsm #(.USE_MEM_READY(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        Instr    = 20'h0;
        ALUFlags = 4'b0000;
        MemReady = 1'b1;

        // Reset held for 3 cycles; every output must be 0.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", State, 0);
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_pcwrite", PCWrite, 0);
        chk("rst_alusrcb", ALUSrcB, 0);
        chk("rst_resultsrc", ResultSrc, 0);
        chk("rst_alusrca", ALUSrcA, 0);
        reset = 1'b1;
        Instr = 20'hE2821;

        // ADD R1,R2,#5: 0,1,7,8
        @(negedge clk); #1;
        chk("addi_decode_state", State, 1);
        chk("addi_decode_regwrite", RegWrite, 0);
        @(negedge clk); ALUFlags = 4'b1111; #1;
        chk("addi_exec_state", State, 7);
        chk("addi_exec_alusrcb", ALUSrcB, 1);
        chk("addi_exec_alusrca", ALUSrcA, 0);
        chk("addi_exec_aluctl", ALUControl, 0);
        chk("addi_exec_regwrite", RegWrite, 0);
        @(negedge clk); ALUFlags = 4'b0000; #1;
        chk("addi_wb_state", State, 8);
        chk("addi_wb_regwrite", RegWrite, 1);
        chk("addi_wb_pcwrite", PCWrite, 0);
        chk("addi_wb_resultsrc", ResultSrc, 0);

        // BEQ with Flags = 0000 (ADD without S must not touch flags)
        @(negedge clk); Instr = 20'h0A000; #1;
        chk("beq0_fetch_state", State, 0);
        chk("beq0_fetch_irwrite", IRWrite, 1);
        chk("beq0_fetch_pcwrite", PCWrite, 1);
        chk("beq0_fetch_alusrcb", ALUSrcB, 2);
        chk("beq0_fetch_resultsrc", ResultSrc, 2);
        @(negedge clk); #1;
        chk("beq0_decode_state", State, 1);
        chk("beq0_decode_immsrc", ImmSrc, 2);
        chk("beq0_decode_regsrc", RegSrc, 1);
        @(negedge clk); #1;
        chk("beq0_branch_state", State, 9);
        chk("beq0_branch_pcwrite", PCWrite, 0);
        chk("beq0_branch_alusrcb", ALUSrcB, 1);

        // SUBS R0,R0,R0 with ALUFlags = 0100 -> Flags = 0100
        @(negedge clk); Instr = 20'hE0500; #1;
        chk("subs_fetch_state", State, 0);
        @(negedge clk); #1;
        chk("subs_decode_state", State, 1);
        @(negedge clk); ALUFlags = 4'b0100; #1;
        chk("subs_exec_state", State, 6);
        chk("subs_exec_alusrcb", ALUSrcB, 0);
        chk("subs_exec_aluctl", ALUControl, 1);
        @(negedge clk); ALUFlags = 4'b0000; #1;
        chk("subs_wb_state", State, 8);
        chk("subs_wb_regwrite", RegWrite, 1);

        // BEQ with Z = 1, fetch stalled one cycle
        @(negedge clk); Instr = 20'h0A000; MemReady = 1'b0; #1;
        chk("beq1_stall_state", State, 0);
        chk("beq1_stall_irwrite", IRWrite, 0);
        chk("beq1_stall_pcwrite", PCWrite, 0);
        @(negedge clk); MemReady = 1'b1; #1;
        chk("beq1_fetch_state", State, 0);
        chk("beq1_fetch_irwrite", IRWrite, 1);
        @(negedge clk); #1;
        chk("beq1_decode_state", State, 1);
        @(negedge clk); #1;
        chk("beq1_branch_state", State, 9);
        chk("beq1_branch_pcwrite", PCWrite, 1);

        // LDR R3,[R4,#8] with 2 wait cycles in MEMREAD
        @(negedge clk); Instr = 20'hE5943; #1;
        chk("ldr_fetch_state", State, 0);
        @(negedge clk); #1;
        chk("ldr_decode_state", State, 1);
        chk("ldr_decode_immsrc", ImmSrc, 1);
        chk("ldr_decode_regsrc", RegSrc, 0);
        @(negedge clk); #1;
        chk("ldr_memadr_state", State, 2);
        chk("ldr_memadr_alusrcb", ALUSrcB, 1);
        chk("ldr_memadr_aluctl", ALUControl, 0);
        @(negedge clk); MemReady = 1'b0; #1;
        chk("ldr_rd_w1_state", State, 3);
        chk("ldr_rd_w1_adrsrc", AdrSrc, 1);
        @(negedge clk); #1;
        chk("ldr_rd_w2_state", State, 3);
        @(negedge clk); MemReady = 1'b1; #1;
        chk("ldr_rd_done_state", State, 3);
        chk("ldr_rd_done_adrsrc", AdrSrc, 1);
        @(negedge clk); #1;
        chk("ldr_wb_state", State, 4);
        chk("ldr_wb_regwrite", RegWrite, 1);
        chk("ldr_wb_resultsrc", ResultSrc, 1);
        chk("ldr_wb_pcwrite", PCWrite, 0);

        // CMP R0,R0 with ALUFlags = 1011 -> Flags = 1011, no register write
        @(negedge clk); Instr = 20'hE1500; #1;
        chk("cmp_fetch_state", State, 0);
        @(negedge clk); #1;
        chk("cmp_decode_state", State, 1);
        @(negedge clk); ALUFlags = 4'b1011; #1;
        chk("cmp_exec_state", State, 6);
        chk("cmp_exec_aluctl", ALUControl, 1);
        @(negedge clk); ALUFlags = 4'b0000; #1;
        chk("cmp_wb_state", State, 8);
        chk("cmp_wb_regwrite", RegWrite, 0);
        chk("cmp_wb_pcwrite", PCWrite, 0);

        // BGT: ~Z & (N==V) holds only if all four flag bits were written
        @(negedge clk); Instr = 20'hCA000; #1;
        chk("bgt_fetch_state", State, 0);
        @(negedge clk); #1;
        chk("bgt_decode_state", State, 1);
        @(negedge clk); #1;
        chk("bgt_branch_state", State, 9);
        chk("bgt_branch_pcwrite", PCWrite, 1);

        // STR EQ with Z = 0: no MemWrite, single MEMWRITE cycle despite MemReady low
        @(negedge clk); Instr = 20'h05840; #1;
        chk("streq_fetch_state", State, 0);
        @(negedge clk); #1;
        chk("streq_decode_state", State, 1);
        chk("streq_decode_regsrc", RegSrc, 2);
        chk("streq_decode_immsrc", ImmSrc, 1);
        @(negedge clk); #1;
        chk("streq_memadr_state", State, 2);
        @(negedge clk); MemReady = 1'b0; #1;
        chk("streq_mw_state", State, 5);
        chk("streq_mw_memwrite", MemWrite, 0);
        chk("streq_mw_adrsrc", AdrSrc, 1);
        @(negedge clk); MemReady = 1'b1; #1;
        chk("streq_exit_state", State, 0);
        chk("streq_exit_memwrite", MemWrite, 0);

        // STR AL with MemReady delayed one cycle: MemWrite high for 2 cycles
        Instr = 20'hE5840;
        @(negedge clk); #1;
        chk("stral_decode_state", State, 1);
        @(negedge clk); #1;
        chk("stral_memadr_state", State, 2);
        @(negedge clk); MemReady = 1'b0; #1;
        chk("stral_mw1_state", State, 5);
        chk("stral_mw1_memwrite", MemWrite, 1);
        @(negedge clk); MemReady = 1'b1; #1;
        chk("stral_mw2_state", State, 5);
        chk("stral_mw2_memwrite", MemWrite, 1);
        @(negedge clk); #1;
        chk("stral_exit_state", State, 0);
        chk("stral_exit_memwrite", MemWrite, 0);

        // ADD R15,R0,R0 -> PCWrite = RegWrite = 1 in ALUWB
        Instr = 20'hE080F;
        @(negedge clk); #1;
        chk("addpc_decode_state", State, 1);
        @(negedge clk); #1;
        chk("addpc_exec_state", State, 6);
        chk("addpc_exec_alusrcb", ALUSrcB, 0);
        @(negedge clk); #1;
        chk("addpc_wb_state", State, 8);
        chk("addpc_wb_regwrite", RegWrite, 1);
        chk("addpc_wb_pcwrite", PCWrite, 1);

        // Undefined op 11 returns to FETCH from DECODE
        @(negedge clk); Instr = 20'hEC000; #1;
        chk("undef_fetch_state", State, 0);
        @(negedge clk); #1;
        chk("undef_decode_state", State, 1);
        @(negedge clk); #1;
        chk("undef_back_state", State, 0);
        chk("undef_back_regwrite", RegWrite, 0);

        // Async reset during MEMWRITE with MemWrite high
        Instr = 20'hE5840;
        @(negedge clk); #1;
        chk("rstmw_decode_state", State, 1);
        @(negedge clk); #1;
        chk("rstmw_memadr_state", State, 2);
        @(negedge clk); MemReady = 1'b0; #1;
        chk("rstmw_mw_state", State, 5);
        chk("rstmw_mw_memwrite", MemWrite, 1);
        #1 reset = 1'b0;
        #1;
        chk("rstmw_async_memwrite", MemWrite, 0);
        chk("rstmw_async_state", State, 0);
        chk("rstmw_async_adrsrc", AdrSrc, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rstmw_held_memwrite", MemWrite, 0);
        reset    = 1'b1;
        MemReady = 1'b1;
        Instr    = 20'h2A000;
        #1;
        chk("rstmw_release_state", State, 0);

        // BCS after reset: C was 1 before reset, must now be 0
        @(negedge clk); #1;
        chk("bcs_decode_state", State, 1);
        @(negedge clk); #1;
        chk("bcs_branch_state", State, 9);
        chk("bcs_branch_pcwrite", PCWrite, 0);
        @(negedge clk); #1;
        chk("bcs_return_state", State, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multicycle sequencer for the ARM-subset datapath. It replaces single-cycle control with a Moore FSM (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK) and sequences one shared ALU and one unified memory across instruction phases. It also holds the NZCV flags register and condition evaluation internally. It drives all datapath mux selects and write enables, and stalls on a memory ready handshake.

Parameters:
USE_MEM_READY, 1, 1 = FETCH/MEMREAD/MEMWRITE wait for MemReady; 0 = MemReady treated as constant 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = in reset)
Instr  in  20  IR bits [31:12]; stable from DECODE until next FETCH completes
ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
MemReady  in  1  memory completes access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction register enable
ResultSrc  out  2  00 = ALUOut reg, 01 = Data reg, 10 = ALU result direct
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ALUSrcA  out  2  00 = RegA, 01 = PC
ALUSrcB  out  2  00 = RegB, 01 = ExtImm, 10 = constant 4
ImmSrc  out  2  00 = data-processing imm8, 01 = mem imm12, 10 = branch imm24
RegSrc  out  2  [0] = read R15 as Rn (branch); [1] = read Rd as 2nd source (store)
RegWrite  out  1  register file write enable
State  out  4  current state code (debug)

Behaviour:
- Reset (reset = 0): state = FETCH, Flags = 0000, CondExReg = 0. All outputs 0 while reset is low. From the first clock edge after release, outputs follow state.
- Field decode:
  - op = Instr[27:26]; I = Instr[25]; cmd = Instr[24:21]; S = Instr[20]; Rd = Instr[15:12].
  - For memory instructions: U = Instr[23]; L = Instr[20].
- Command decode:
  - cmd 0100 = ADD, 0010 = SUB, 0000 = AND, 1100 = ORR.
  - 1010 = CMP: executes as SUB with NoWrite = 1 and FlagW forced to 11.
  - Any other cmd: ADD with NoWrite = 1 and FlagW = 00.
- FlagW when S = 1: ADD/SUB = 11; AND/ORR = 10.
- Condition evaluation (CondEx, combinational from Instr[31:28] and Flags):
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - 1110 = 1; 1111 = 0.
- States, per-state outputs and transitions (unlisted outputs are 0):
  - FETCH(0): AdrSrc 0; ALUSrcA 01; ALUSrcB 10; ResultSrc 10; ADD. IRWrite = PCWrite = MemReady. Stays in FETCH until MemReady, then goes to DECODE.
  - DECODE(1): ALUSrcA 01; ALUSrcB 10; ResultSrc 10; ADD; RegSrc and ImmSrc per op. Next state by op: 01 -> MEMADR; 00 & ~I -> EXECUTER; 00 & I -> EXECUTEI; 10 -> BRANCH; 11 -> FETCH (undefined op, no side effects).
  - MEMADR(2): ALUSrcA 00; ALUSrcB 01; ADD if U else SUB. Captures CondExReg = CondEx. Next: MEMREAD if L, else MEMWRITE.
  - MEMREAD(3): AdrSrc 1. Waits for MemReady, then MEMWB.
  - MEMWB(4): ResultSrc 01; RegWrite = CondExReg; PCWrite = CondExReg & (Rd == 15). Next: FETCH.
  - MEMWRITE(5): AdrSrc 1; MemWrite = CondExReg. If CondExReg = 0, goes to FETCH next cycle without waiting. Otherwise waits for MemReady, with MemWrite held high, then goes to FETCH.
  - EXECUTER(6) / EXECUTEI(7): ALUSrcA 00; ALUSrcB 00 or 01 respectively; ALUControl from cmd. Captures CondExReg = CondEx. Next: ALUWB.
  - ALUWB(8): ResultSrc 00; RegWrite = CondExReg & ~NoWrite; PCWrite = RegWrite & (Rd == 15). Next: FETCH.
  - BRANCH(9): ALUSrcA 00; ALUSrcB 01; ResultSrc 10; ADD; RegSrc[0] = 1; ImmSrc 10; PCWrite = CondEx. Next: FETCH.
- Flags update: at the end of EXECUTER/EXECUTEI when CondEx = 1. Flags[3:2] <= ALUFlags[3:2] if FlagW[1]; Flags[1:0] <= ALUFlags[1:0] if FlagW[0].
- Condition timing: CondEx is always evaluated against pre-update flags. Writeback uses only CondExReg, so a conditional SUBS does not see its own result.
- Latency: data-processing 4 cycles; load 5; store 4; branch 3 (each plus any MemReady wait cycles).
- Async reset mid-instruction aborts it. No partial write-enable pulse is emitted after reset asserts.

Test Plan:
- Reset low 3 cycles, then release with MemReady = 1 and Instr = 0xE2821 (ADD R1,R2,#5) -> State sequence 0,1,7,8,0. ALUSrcB = 01 in state 7. RegWrite = 1 only in state 8. Flags stay 0000.
- SUBS R0,R0,R0 (0xE0500), with ALUFlags = 0100 at EXECUTER -> Flags = 0100. A following BEQ (Instr[31:24] = 0x0A) -> PCWrite = 1 in BRANCH. The same BEQ with Flags = 0000 -> PCWrite = 0 and State still returns to 0.
- LDR R3,[R4,#8] (0xE5943) with MemReady low for 2 cycles in MEMREAD -> State holds 3 for those cycles. AdrSrc = 1. RegWrite = 1 in state 4 with ResultSrc = 01.
- STR with cond = EQ and Z = 0 -> MemWrite never asserts and MEMWRITE exits after 1 cycle. STR with AL and MemReady delayed 1 cycle -> MemWrite high for 2 cycles.
- CMP (cmd 1010, S = 1) -> RegWrite = 0 in ALUWB and Flags updated with all four bits. ADD with Rd = 15 -> PCWrite = RegWrite = 1 in ALUWB.
- Assert reset during MEMWRITE with MemWrite high -> MemWrite = 0 immediately (asynchronously). State = 0 and Flags = 0000 after release.
